// File: rtl/spi_mult_master.sv
// SPI master for the SmolBoi multiplier slave: shifts {op_a, op_b} out, idles GAP_PERIODS, shifts the product in.
// Optional self-check of the returned product is enabled by defining SPI_MULT_CHECK_EN.
module spi_mult_master #(
   parameter int OP_WIDTH    = 4,
   parameter int HALF_DIV    = 5,
   parameter int GAP_PERIODS = 5
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  start,
   input  logic [OP_WIDTH-1:0]   op_a,
   input  logic [OP_WIDTH-1:0]   op_b,
   output logic                  busy,
   output logic                  done,
   output logic [2*OP_WIDTH-1:0] result,
   output logic                  mismatch,
   output logic                  SCLK,
   output logic                  CS,
   output logic                  MOSI,
   input  logic                  MISO
);

   localparam int RW   = 2 * OP_WIDTH;
   localparam int PMAX = (RW > GAP_PERIODS) ? RW : GAP_PERIODS;
   localparam int HW   = $clog2(HALF_DIV);
   localparam int PW   = $clog2(PMAX);

   typedef enum logic [2:0] {IDLE, SETUP, SEND, GAP, RECV, FINISH} state_t;

   state_t        state;
   logic [HW-1:0] hcnt;
   logic [PW-1:0] pcnt;
   logic [RW-1:0] tx;
   logic [RW-1:0] rx;
   logic          half_end;
   logic          last_period;
   logic          accept;

   assign half_end    = (hcnt == HW'(HALF_DIV - 1));
   assign last_period = (state == GAP) ? (pcnt == PW'(GAP_PERIODS - 1)) : (pcnt == PW'(RW - 1));
   assign accept      = (state == IDLE) && start && !done;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state  <= IDLE;
         hcnt   <= '0;
         pcnt   <= '0;
         tx     <= '0;
         rx     <= '0;
         SCLK   <= 1'b0;
         CS     <= 1'b0;
         MOSI   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               busy <= 1'b0;
               if (accept) begin
                  tx    <= {op_a, op_b};
                  CS    <= 1'b1;
                  MOSI  <= op_a[OP_WIDTH-1];
                  busy  <= 1'b1;
                  hcnt  <= '0;
                  pcnt  <= '0;
                  state <= SETUP;
               end
            end
            SETUP: begin
               if (half_end) begin
                  hcnt  <= '0;
                  SCLK  <= 1'b1;
                  state <= SEND;
               end else begin
                  hcnt <= hcnt + HW'(1);
               end
            end
            SEND, GAP, RECV: begin
               if (!half_end) begin
                  hcnt <= hcnt + HW'(1);
               end else if (SCLK) begin
                  hcnt <= '0;
                  SCLK <= 1'b0;
                  if (state == SEND) begin
                     tx   <= tx << 1;
                     MOSI <= last_period ? 1'b0 : tx[RW-2];
                  end
               end else begin
                  // End of a period: the rising edge of the next period starts the next phase,
                  // so the first result bit is sampled on the edge leaving GAP.
                  hcnt <= '0;
                  pcnt <= last_period ? '0 : pcnt + PW'(1);
                  SCLK <= !((state == RECV) && last_period);
                  if (((state == RECV) && !last_period) || ((state == GAP) && last_period))
                     rx <= {rx[RW-2:0], MISO};
                  if (last_period) begin
                     case (state)
                        SEND:    state <= GAP;
                        GAP:     state <= RECV;
                        default: state <= FINISH;
                     endcase
                  end
               end
            end
            FINISH: begin
               result <= rx;
               CS     <= 1'b0;
               done   <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SPI_MULT_CHECK_EN
   logic [RW-1:0] expected;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         expected <= '0;
         mismatch <= 1'b0;
      end else begin
         if (accept)
            expected <= RW'(op_a) * RW'(op_b);
         if (state == FINISH)
            mismatch <= (rx != expected);
      end
   end
`else
   assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_spi_mult_master.sv
// Scoreboard bench for spi_mult_master with a behavioural multiplier slave on the SPI pins.
module tb_spi_mult_master;

   localparam int W     = 4;
   localparam int H     = 5;
   localparam int G     = 5;
   localparam int RW    = 2 * W;
   localparam int NRISE = 4 * W + G;
   localparam int NCYC  = H + 2 * H * NRISE + 1;

   logic          CLK;
   logic          RST_N;
   logic          start;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic          busy;
   logic          done;
   logic [RW-1:0] result;
   logic          mismatch;
   logic          SCLK;
   logic          CS;
   logic          MOSI;
   logic          MISO;

   spi_mult_master #(.OP_WIDTH(W), .HALF_DIV(H), .GAP_PERIODS(G)) dut (
      .CLK(CLK), .RST_N(RST_N), .start(start), .op_a(op_a), .op_b(op_b),
      .busy(busy), .done(done), .result(result), .mismatch(mismatch),
      .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [RW-1:0] ops;
      logic [RW-1:0] res;
      logic          mis;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Behavioural slave: captures the operands on SCLK rises, returns the product MSB first.
   int            rise_cnt = 0;
   logic [RW-1:0] mosi_sh  = '0;
   logic [RW-1:0] resp;
   bit            bad_slave = 1'b0;

   always @(posedge CS) rise_cnt = 0;

   always @(posedge SCLK) begin
      if (CS) begin
         rise_cnt++;
         if (rise_cnt <= RW) mosi_sh = {mosi_sh[RW-2:0], MOSI};
      end
   end

   always @(negedge SCLK) begin
      if (CS && rise_cnt >= RW + G && rise_cnt < NRISE) begin
         resp = bad_slave ? RW'(8'h07) : RW'(mosi_sh[RW-1:W]) * RW'(mosi_sh[W-1:0]);
         MISO = resp[NRISE-1-rise_cnt];
      end
   end

   // Monitor: pops the scoreboard on every done pulse.
   int   cyc = 0;
   int   accept_cyc = 0;
   logic busy_q = 1'b0;
   exp_t e;

   always @(posedge CLK) cyc++;

   always @(negedge CLK) begin
      if (RST_N) begin
         if (busy && !busy_q) accept_cyc = cyc;
         if (done) begin
            if (sb.size() == 0) begin
               check("spurious_done", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("result", 32'(result), 32'(e.res));
               check("mosi_bits", 32'(mosi_sh), 32'(e.ops));
               check("sclk_rises", 32'(rise_cnt), 32'(NRISE));
               check("done_latency", 32'(cyc - accept_cyc), 32'(NCYC));
               check("mismatch", 32'(mismatch), 32'(e.mis));
               check("busy_at_done", 32'(busy), 32'd1);
            end
         end
      end
      busy_q = busy;
   end

   task automatic go(input logic [W-1:0] a, input logic [W-1:0] b, input bit bad);
      exp_t x;
      @(negedge CLK);
      op_a      = a;
      op_b      = b;
      bad_slave = bad;
      start     = 1'b1;
      x.ops = {a, b};
      x.res = bad ? RW'(8'h07) : RW'(a) * RW'(b);
      x.mis = bad;
      sb.push_back(x);
      @(negedge CLK);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!done && n < 2000);
      if (!done) begin
         check("done_timeout", 32'd0, 32'd1);
         sb.delete();
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      RST_N = 1'b0;
      start = 1'b0;
      op_a  = '0;
      op_b  = '0;
      MISO  = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_sclk", 32'(SCLK), 32'd0);
      check("rst_cs", 32'(CS), 32'd0);
      check("rst_mosi", 32'(MOSI), 32'd0);
      check("rst_busy_done", 32'({busy, done}), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_mismatch", 32'(mismatch), 32'd0);
      RST_N = 1'b1;

      go(4'd1, 4'd6, 1'b0);
      wait_done();

      go(4'd15, 4'd15, 1'b0);
      wait_done();
      @(negedge CLK);
      check("post_done_sclk", 32'(SCLK), 32'd0);
      check("post_done_cs", 32'(CS), 32'd0);
      check("post_done_busy", 32'(busy), 32'd0);
      check("post_done_done", 32'(done), 32'd0);

      // start held from the done cycle: ignored there, accepted one cycle later
      go(4'd0, 4'd9, 1'b0);
      wait_done();
      op_a  = 4'd2;
      op_b  = 4'd3;
      start = 1'b1;
      e.ops = {4'd2, 4'd3};
      e.res = 8'd6;
      e.mis = 1'b0;
      sb.push_back(e);
      @(negedge CLK);
      check("start_at_done_ignored", 32'(busy), 32'd0);
      check("cs_gap_low", 32'(CS), 32'd0);
      @(negedge CLK);
      start = 1'b0;
      check("restart_busy", 32'(busy), 32'd1);
      check("restart_cs", 32'(CS), 32'd1);
      wait_done();

      // start mid-SEND with new operands must be ignored
      go(4'd5, 4'd7, 1'b0);
      repeat (30) @(negedge CLK);
      op_a  = 4'd9;
      op_b  = 4'd2;
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      wait_done();
      repeat (20) @(negedge CLK);

      // reset while receiving
      go(4'd7, 4'd7, 1'b0);
      for (int i = 0; i < 400 && rise_cnt < 15; i++) @(negedge CLK);
      check("reached_recv", 32'(rise_cnt >= 15), 32'd1);
      #2 RST_N = 1'b0;
      #1;
      check("abort_sclk", 32'(SCLK), 32'd0);
      check("abort_cs", 32'(CS), 32'd0);
      check("abort_mosi", 32'(MOSI), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_result", 32'(result), 32'd0);
      sb.delete();
      @(negedge CLK);
      RST_N = 1'b1;
      go(4'd3, 4'd5, 1'b0);
      wait_done();

`ifdef SPI_MULT_CHECK_EN
      go(4'd1, 4'd6, 1'b1);
      wait_done();
      go(4'd1, 4'd6, 1'b0);
      wait_done();
`endif

      repeat (5) @(negedge CLK);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
